// File: rtl/rv32i_types_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types_pkg
//   Shared scalar-pipeline types. Only the register-select type is needed by
//   the vector scoreboard, which reuses it for vector register indices.
// ---------------------------------------------------------------------------
package rv32i_types_pkg;

  localparam int REGSEL_W = 5;

  typedef logic [REGSEL_W-1:0] regsel_t;

endpackage : rv32i_types_pkg

// File: rtl/rv32v_types_pkg.sv
// ---------------------------------------------------------------------------
// rv32v_types_pkg
//   Vector-side constants and types for the issue scoreboard:
//     VSB_NUM_VREGS     architectural vector registers
//     VSB_MAX_INFLIGHT  outstanding writes tracked per register
//     vsb_cnt_t         per-register pending-write counter
//     vsb_hazard_t      breakdown of the stall causes
// ---------------------------------------------------------------------------
package rv32v_types_pkg;

  import rv32i_types_pkg::*;

  localparam int VSB_NUM_VREGS    = 32;
  localparam int VSB_MAX_INFLIGHT = 3;
  localparam int VSB_CNT_W        = $clog2(VSB_MAX_INFLIGHT + 1);

  typedef logic [VSB_CNT_W-1:0] vsb_cnt_t;

  // Individual hazard sources; vhazard_stall is their OR.
  typedef struct packed {
    logic raw;  // a read source (or v0 mask) has a write in flight
    logic cap;  // destination counter is already at capacity
    logic waw;  // destination has any write in flight (optional policy)
  } vsb_hazard_t;

  function automatic logic vsb_any_hazard(vsb_hazard_t h);
    return h.raw | h.cap | h.waw;
  endfunction

endpackage : rv32v_types_pkg

// File: rtl/vsb_pend_counter.sv
// ---------------------------------------------------------------------------
// vsb_pend_counter
//   Pending-write counter for one vector register. Counts up on issue,
//   down on last-uop retire, saturates at both ends, and is cleared by flush.
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     inc_i         a write to this register issued this cycle
//     dec_i         a write to this register retired this cycle
//     clr_i         discard all tracking (wins over inc/dec)
//     nonzero_o     at least one write outstanding
//     full_o        count equals MAX
//     underflow_o   retire seen while count is zero (no matching issue)
// ---------------------------------------------------------------------------
module vsb_pend_counter #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic nonzero_o,
  output logic full_o,
  output logic underflow_o
);

  localparam int CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign nonzero_o   = (cnt_q != '0);
  assign full_o      = (cnt_q == CNT_W'(MAX));
  // A simultaneous issue masks the retire: the pair nets to zero.
  assign underflow_o = dec_i & ~inc_i & ~nonzero_o;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && nonzero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: every counter is reset; the scoreboard must start empty, so this
  // small array is real state, not a RAM that could be left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so all counters sample pre-edge values together.
      cnt_q <= cnt_d;
    end
  end

endmodule : vsb_pend_counter

// File: rtl/stage4_vreg_scoreboard.sv
// ---------------------------------------------------------------------------
// stage4_vreg_scoreboard
//   Issue-side RAW/WAW scoreboard for the vector register file. Tracks
//   in-flight vector writes per register from issue until last-uop retire
//   and raises a combinational stall for the hazard unit.
//
//   Build option:
//     VSB_WAW_STALL_EN  when defined, also stall any write whose destination
//                       already has a write in flight (at most one per reg).
//                       When undefined, WAW is allowed up to MAX_INFLIGHT.
//
//   Ports:
//     CLK, nRST              clock, asynchronous active-low reset
//     issue_*                instruction at execute entry; issue_fire is the
//                            hazard unit's accept for this cycle
//     retire_valid/_vd/_vregwen  last uop leaving mem and its destination
//     flush                  discard all in-flight tracking
//     vhazard_stall          issue must hold (same-cycle, registered state)
//     vsb_busy               any write outstanding
//     vsb_error              sticky protocol error (underflow, or fire
//                            while stalled); cleared only by nRST
// ---------------------------------------------------------------------------
module stage4_vreg_scoreboard
  import rv32i_types_pkg::*;
  import rv32v_types_pkg::*;
#(
  parameter int NUM_VREGS    = VSB_NUM_VREGS,
  parameter int MAX_INFLIGHT = VSB_MAX_INFLIGHT
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       issue_valid,
  input  logic [4:0] issue_vs1,
  input  logic [4:0] issue_vs2,
  input  logic [4:0] issue_vd,
  input  logic       issue_vs1_used,
  input  logic       issue_vs2_used,
  input  logic       issue_mask_en,
  input  logic       issue_vregwen,
  input  logic       issue_fire,
  input  logic       retire_valid,
  input  logic [4:0] retire_vd,
  input  logic       retire_vregwen,
  input  logic       flush,
  output logic       vhazard_stall,
  output logic       vsb_busy,
  output logic       vsb_error
);

  logic [NUM_VREGS-1:0] pend_nz;
  logic [NUM_VREGS-1:0] pend_full;
  logic [NUM_VREGS-1:0] underflow;

  vsb_hazard_t hazard;
  logic        issue_accept;
  logic        fire_err;
  logic        err_q;
  logic        err_d;

  // ---- hazard detection (registered state only, no retire bypass) --------
  always_comb begin
    hazard     = '0;
    hazard.raw = issue_valid &
                 ((issue_vs1_used & pend_nz[regsel_t'(issue_vs1)]) |
                  (issue_vs2_used & pend_nz[regsel_t'(issue_vs2)]) |
                  (issue_mask_en  & pend_nz[0]));
    hazard.cap = issue_valid & issue_vregwen & pend_full[regsel_t'(issue_vd)];
`ifdef VSB_WAW_STALL_EN
    hazard.waw = issue_valid & issue_vregwen & pend_nz[regsel_t'(issue_vd)];
`else
    hazard.waw = 1'b0;
`endif
  end

  assign vhazard_stall = vsb_any_hazard(hazard);

  // A fire against our own stall is a hazard-unit bug: drop it, flag it.
  assign issue_accept = issue_fire & ~vhazard_stall & issue_vregwen;
  assign fire_err     = issue_fire & vhazard_stall;

  // ---- per-register counters --------------------------------------------
  for (genvar r = 0; r < NUM_VREGS; r++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = issue_accept & (regsel_t'(issue_vd) == regsel_t'(r));
    assign dec = retire_valid & retire_vregwen &
                 (regsel_t'(retire_vd) == regsel_t'(r));

    vsb_pend_counter #(
      .MAX (MAX_INFLIGHT)
    ) u_cnt (
      .clk         (CLK),
      .rst_n       (nRST),
      .inc_i       (inc),
      .dec_i       (dec),
      .clr_i       (flush),
      .nonzero_o   (pend_nz[r]),
      .full_o      (pend_full[r]),
      .underflow_o (underflow[r])
    );
  end

  assign vsb_busy = |pend_nz;

  // ---- sticky error; flush deliberately leaves it set ---------------------
  assign err_d = err_q | fire_err | (|underflow);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign vsb_error = err_q;

endmodule : stage4_vreg_scoreboard

// File: tb/tb_stage4_vreg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_stage4_vreg_scoreboard
//   Directed scoreboard bench. Each step drives one cycle of stimulus,
//   pushes the expected stall/busy/error from a behavioural model onto a
//   queue, then pops and compares against the DUT before the clock edge.
// ---------------------------------------------------------------------------
module tb_stage4_vreg_scoreboard;

  localparam int NREG = 32;
  localparam int MAXF = 3;

  logic       CLK;
  logic       nRST;
  logic       issue_valid;
  logic [4:0] issue_vs1;
  logic [4:0] issue_vs2;
  logic [4:0] issue_vd;
  logic       issue_vs1_used;
  logic       issue_vs2_used;
  logic       issue_mask_en;
  logic       issue_vregwen;
  logic       issue_fire;
  logic       retire_valid;
  logic [4:0] retire_vd;
  logic       retire_vregwen;
  logic       flush;
  logic       vhazard_stall;
  logic       vsb_busy;
  logic       vsb_error;

  stage4_vreg_scoreboard dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .issue_valid    (issue_valid),
    .issue_vs1      (issue_vs1),
    .issue_vs2      (issue_vs2),
    .issue_vd       (issue_vd),
    .issue_vs1_used (issue_vs1_used),
    .issue_vs2_used (issue_vs2_used),
    .issue_mask_en  (issue_mask_en),
    .issue_vregwen  (issue_vregwen),
    .issue_fire     (issue_fire),
    .retire_valid   (retire_valid),
    .retire_vd      (retire_vd),
    .retire_vregwen (retire_vregwen),
    .flush          (flush),
    .vhazard_stall  (vhazard_stall),
    .vsb_busy       (vsb_busy),
    .vsb_error      (vsb_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       valid;
    logic [4:0] vs1;
    logic       vs1u;
    logic [4:0] vs2;
    logic       vs2u;
    logic       mask;
    logic [4:0] vd;
    logic       wen;
    logic       fire;        // request; bench gates it with the expected stall
    logic       force_fire;  // fire regardless of stall (protocol error case)
    logic       rv;
    logic [4:0] rvd;
    logic       rwen;
    logic       fl;
  } stim_t;

  typedef struct {
    string name;
    logic  stall;
    logic  busy;
    logic  err;
  } exp_t;

  exp_t exp_q[$];
  int   pend_m[NREG];
  bit   err_m;
  int   tests;
  int   fails;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall(input stim_t s);
    bit raw;
    bit cap;
    bit waw;
    raw = s.valid & ((s.vs1u & (pend_m[s.vs1] != 0)) |
                     (s.vs2u & (pend_m[s.vs2] != 0)) |
                     (s.mask & (pend_m[0] != 0)));
    cap = s.valid & s.wen & (pend_m[s.vd] == MAXF);
`ifdef VSB_WAW_STALL_EN
    waw = s.valid & s.wen & (pend_m[s.vd] != 0);
`else
    waw = 1'b0;
`endif
    return raw | cap | waw;
  endfunction

  function automatic bit model_busy();
    for (int r = 0; r < NREG; r++) if (pend_m[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) pend_m[r] = 0;
  endfunction

  // One cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input string name, input stim_t s);
    exp_t e;
    exp_t got;
    bit   st;
    bit   fire_act;
    st       = model_stall(s);
    fire_act = s.force_fire | (s.fire & ~st);

    issue_valid    = s.valid;
    issue_vs1      = s.vs1;
    issue_vs1_used = s.vs1u;
    issue_vs2      = s.vs2;
    issue_vs2_used = s.vs2u;
    issue_mask_en  = s.mask;
    issue_vd       = s.vd;
    issue_vregwen  = s.wen;
    issue_fire     = fire_act;
    retire_valid   = s.rv;
    retire_vd      = s.rvd;
    retire_vregwen = s.rwen;
    flush          = s.fl;

    e.name  = name;
    e.stall = st;
    e.busy  = model_busy();
    e.err   = err_m;
    exp_q.push_back(e);

    #2;
    got = exp_q.pop_front();
    check({got.name, ".stall"}, vhazard_stall, got.stall);
    check({got.name, ".busy"},  vsb_busy,      got.busy);
    check({got.name, ".err"},   vsb_error,     got.err);

    @(posedge CLK);
    if (fire_act && st) err_m = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      bit inc;
      bit dec;
      inc = fire_act & ~st & s.wen & (s.vd == 5'(r));
      dec = s.rv & s.rwen & (s.rvd == 5'(r));
      if (dec && !inc && pend_m[r] == 0) err_m = 1'b1;
      if (s.fl) pend_m[r] = 0;
      else if (inc && !dec && pend_m[r] < MAXF) pend_m[r]++;
      else if (dec && !inc && pend_m[r] > 0) pend_m[r]--;
    end
    @(negedge CLK);
  endtask

  function automatic stim_t w(input logic [4:0] vd);
    stim_t s = '0;
    s.valid = 1'b1; s.vd = vd; s.wen = 1'b1; s.fire = 1'b1;
    return s;
  endfunction

  function automatic stim_t rd(input logic [4:0] vs1, input logic fire);
    stim_t s = '0;
    s.valid = 1'b1; s.vs1 = vs1; s.vs1u = 1'b1; s.fire = fire;
    return s;
  endfunction

  function automatic stim_t ret(input logic [4:0] vd);
    stim_t s = '0;
    s.rv = 1'b1; s.rvd = vd; s.rwen = 1'b1;
    return s;
  endfunction

  task automatic drain(input logic [4:0] vd);
    for (int k = 0; k < MAXF && pend_m[vd] > 0; k++) step("drain", ret(vd));
  endtask

  initial begin
    stim_t s;
    tests = 0;
    fails = 0;
    err_m = 1'b0;
    model_clear();
    nRST = 1'b0;
    issue_valid = 0; issue_vs1 = 0; issue_vs2 = 0; issue_vd = 0;
    issue_vs1_used = 0; issue_vs2_used = 0; issue_mask_en = 0;
    issue_vregwen = 0; issue_fire = 0; retire_valid = 0; retire_vd = 0;
    retire_vregwen = 0; flush = 0;

    #3;
    check("reset.stall", vhazard_stall, 1'b0);
    check("reset.busy",  vsb_busy,      1'b0);
    check("reset.err",   vsb_error,     1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // RAW on v5, no bypass from same-cycle retire
    step("w5", w(5'd5));
    step("raw5", rd(5'd5, 1'b0));
    s = rd(5'd5, 1'b1); s.rv = 1'b1; s.rvd = 5'd5; s.rwen = 1'b1;
    step("raw5_retire_same", s);
    step("raw5_after", rd(5'd5, 1'b1));

    // v0 mask dependency
    step("w0", w(5'd0));
    s = '0; s.valid = 1'b1; s.mask = 1'b1; s.vs1 = 5'd1; s.vs2 = 5'd2;
    step("mask_on", s);
    s.mask = 1'b0; s.fire = 1'b1;
    step("mask_off", s);
    step("ret0", ret(5'd0));

    // capacity (or WAW) on v7
    step("w7a", w(5'd7));
    step("w7b", w(5'd7));
    step("w7c", w(5'd7));
    step("w7d_cap", w(5'd7));
    step("ret7", ret(5'd7));
    step("w7d_ok", w(5'd7));
    drain(5'd7);
    step("v7_idle", rd(5'd7, 1'b1));

    // issue and retire v9 in the same cycle
    step("w9", w(5'd9));
    s = w(5'd9); s.rv = 1'b1; s.rvd = 5'd9; s.rwen = 1'b1;
    step("w9_ret9", s);
    step("rd9", rd(5'd9, 1'b0));
    drain(5'd9);

    // flush overrides a concurrent issue
    step("w1", w(5'd1));
    step("w2", w(5'd2));
    step("w3", w(5'd3));
    s = w(5'd4); s.fl = 1'b1;
    step("flush_w4", s);
    for (int r = 1; r <= 4; r++) step("post_flush_rd", rd(5'(r), 1'b1));

    // underflow is sticky across flush
    step("ret12_empty", ret(5'd12));
    s = '0; s.fl = 1'b1;
    step("flush_err", s);
    step("err_hold", '0);

    // async reset mid-cycle with a pending write and a blocked reader
    step("w6", w(5'd6));
    s = rd(5'd6, 1'b0);
    issue_valid = 1'b1; issue_vs1 = 5'd6; issue_vs1_used = 1'b1; issue_fire = 1'b0;
    #2;
    check("pre_rst.stall", vhazard_stall, 1'b1);
    nRST = 1'b0;
    #1;
    check("in_rst.stall", vhazard_stall, 1'b0);
    check("in_rst.busy",  vsb_busy,      1'b0);
    check("in_rst.err",   vsb_error,     1'b0);
    model_clear();
    err_m = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // fire while stalled: flagged, and the write must not be counted
    step("w3_again", w(5'd3));
    s = rd(5'd3, 1'b0); s.vd = 5'd3; s.wen = 1'b1; s.force_fire = 1'b1;
    step("fire_stalled", s);
    step("ret3", ret(5'd3));
    step("final_idle", '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_stage4_vreg_scoreboard
